// File: rtl/hamming_encode_stream.sv
// Two-stage streaming extended-Hamming (SECDED) encoder with valid/ready flow control,
// per-word XOR error injection and transfer/injection counters.
module hamming_encode_stream #(
  parameter  int DATA_WIDTH  = 32,
  // Smallest r with 2^r >= DATA_WIDTH + r + 1; exact for DATA_WIDTH >= 4.
  localparam int ADDR_WIDTH  = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH) + 1),
  localparam int CODE_BITS   = ADDR_WIDTH + 1,
  localparam int CODED_WIDTH = DATA_WIDTH + CODE_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [CODED_WIDTH-1:0] inj_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CODED_WIDTH-1:0] out_data,
  output logic [15:0]            word_count,
  output logic [15:0]            inj_count
);

  // Scatter payload into non-power-of-2 positions and fill Hamming parity at 2^k; bit 0 left clear.
  function automatic logic [CODED_WIDTH-1:0] f_scatter_parity(input logic [DATA_WIDTH-1:0] d);
    logic [CODED_WIDTH-1:0] c;
    logic                   p;
    int                     j;
    c = '0;
    j = 0;
    for (int pos = 1; pos < CODED_WIDTH; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[j];
        j++;
      end
    end
    for (int k = 0; k < ADDR_WIDTH; k++) begin
      p = 1'b0;
      for (int pos = 1; pos < CODED_WIDTH; pos++) begin
        if ((((pos >> k) & 1) == 1) && ((pos & (pos - 1)) != 0))
          p = p ^ c[pos];
      end
      c[1 << k] = p;
    end
    return c;
  endfunction

  // Overall parity over the finished Hamming word, then the injection mask on top.
  function automatic logic [CODED_WIDTH-1:0] f_seal(input logic [CODED_WIDTH-1:0] c,
                                                    input logic [CODED_WIDTH-1:0] m);
    logic [CODED_WIDTH-1:0] s;
    s    = c;
    s[0] = ^c[CODED_WIDTH-1:1];
    return s ^ m;
  endfunction

  logic                   w_adv1;
  logic                   w_adv2;
  logic                   w_out_fire;

  logic                   r_s1_valid;
  logic [CODED_WIDTH-1:0] r_s1_code;
  logic [CODED_WIDTH-1:0] r_s1_mask;
  logic                   r_s2_valid;
  logic                   r_s2_inj;
  logic [CODED_WIDTH-1:0] r_out_data;
  logic [15:0]            r_word_count;
  logic [15:0]            r_inj_count;

  assign w_adv2     = !r_s2_valid || out_ready;
  assign w_adv1     = !r_s1_valid || w_adv2;
  assign w_out_fire = r_s2_valid && out_ready;

  assign in_ready   = w_adv1 && !rst;
  assign out_valid  = r_s2_valid && !rst;
  assign out_data   = r_out_data;
  assign word_count = r_word_count;
  assign inj_count  = r_inj_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_s2_inj     <= 1'b0;
      r_word_count <= '0;
      r_inj_count  <= '0;
    end else begin
      if (w_adv1) r_s1_valid <= in_valid;
      if (w_adv2) begin
        r_s2_valid <= r_s1_valid;
        r_s2_inj   <= r_s1_valid && (|r_s1_mask);
      end
      if (w_out_fire) begin
        r_word_count <= r_word_count + 16'd1;
        if (r_s2_inj) r_inj_count <= r_inj_count + 16'd1;
      end
    end
  end

  // Stage 1: scattered data + Hamming parity, mask captured alongside
  always_ff @(posedge clk) begin
    if (w_adv1 && in_valid) begin
      r_s1_code <= f_scatter_parity(in_data);
      r_s1_mask <= inj_mask;
    end
  end

  // Stage 2: overall parity and injection, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= '0;
    end else if (w_adv2 && r_s1_valid) begin
      r_out_data <= f_seal(r_s1_code, r_s1_mask);
    end
  end

endmodule

// File: tb/tb_hamming_encode_stream.sv
// Bench for hamming_encode_stream: a 4-bit instance for directed/flow-control/wrap vectors and a
// 32-bit instance for random integrity checks, both against a syndrome-based reference model.
`timescale 1ns/1ps
module tb_hamming_encode_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1;
  logic [3:0]  in_data4 = '0;
  logic [7:0]  mask4 = '0, out_data4;
  logic [15:0] wc4, ic4;

  logic        in_valid32 = 1'b0, in_ready32, out_valid32, out_ready32 = 1'b1;
  logic [31:0] in_data32 = '0;
  logic [38:0] mask32 = '0, out_data32;
  logic [15:0] wc32, ic32;

  hamming_encode_stream #(.DATA_WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .inj_mask(mask4), .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .word_count(wc4), .inj_count(ic4));

  hamming_encode_stream #(.DATA_WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32),
    .inj_mask(mask32), .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32),
    .word_count(wc32), .inj_count(ic32));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: a set data bit at position p contributes p to the syndrome; parity bits cancel it.
  function automatic logic [63:0] ref_encode(input logic [63:0] d, input int cw);
    logic [63:0] c;
    int          syn;
    int          j;
    c = '0; syn = 0; j = 0;
    for (int pos = 1; pos < cw; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (d[j]) begin
          c[pos] = 1'b1;
          syn = syn ^ pos;
        end
        j++;
      end
    end
    for (int k = 0; (1 << k) < cw; k++)
      if (syn[k]) c[1 << k] = 1'b1;
    c[0] = ^c;
    return c;
  endfunction

  function automatic int syndrome(input logic [63:0] c, input int cw);
    int s;
    s = 0;
    for (int pos = 1; pos < cw; pos++)
      if (c[pos]) s = s ^ pos;
    return s;
  endfunction

  function automatic logic [31:0] extract32(input logic [38:0] c);
    logic [31:0] x;
    int          j;
    x = '0; j = 0;
    for (int pos = 1; pos < 39; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        x[j] = c[pos];
        j++;
      end
    end
    return x;
  endfunction

  // 4-bit instance scoreboard
  logic [7:0]  q4[$];
  bit          qi4[$];
  logic [7:0]  log4[$];
  int          logc4[$];
  logic [15:0] mw4 = '0, mi4 = '0;
  int          n4 = 0, cyc = 0;
  bit          stall4 = 1'b0, was_rst4 = 1'b0;
  logic [7:0]  stall_d4 = '0;

  always @(negedge clk) begin
    logic exp_rdy;
    cyc++;
    if (rst) begin
      q4.delete(); qi4.delete();
      mw4 = '0; mi4 = '0; n4 = 0; stall4 = 1'b0; was_rst4 = 1'b1;
      chk("rst_in_ready4", in_ready4, 0);
      chk("rst_out_valid4", out_valid4, 0);
    end else begin
      if (was_rst4) chk("rst_out_data4", out_data4, 0);
      was_rst4 = 1'b0;
      chk("word_count4", wc4, mw4);
      chk("inj_count4", ic4, mi4);
      exp_rdy = (q4.size() < 2) || out_ready4;
      chk("in_ready4", in_ready4, exp_rdy);
      if (stall4) begin
        chk("stall_valid4", out_valid4, 1);
        chk("stall_data4", out_data4, stall_d4);
      end
      if (out_valid4) begin
        if (q4.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out4 actual=%0h required=none", out_data4);
        end else begin
          chk("out_data4", out_data4, q4[0]);
          if (out_ready4) begin
            if (qi4[0]) mi4 = mi4 + 16'd1;
            mw4 = mw4 + 16'd1;
            n4++;
            void'(q4.pop_front()); void'(qi4.pop_front());
            log4.push_back(out_data4); logc4.push_back(cyc);
          end
        end
      end
      stall4   = out_valid4 && !out_ready4;
      stall_d4 = out_data4;
      if (in_valid4 && in_ready4) begin
        q4.push_back(ref_encode({60'd0, in_data4}, 8) ^ {56'd0, mask4});
        qi4.push_back(mask4 != 8'h00);
      end
    end
  end

  // 32-bit instance scoreboard with independent codeword integrity checks
  logic [38:0] q32[$];
  logic [31:0] qd32[$];
  int          n32 = 0;

  always @(negedge clk) begin
    if (rst) begin
      q32.delete(); qd32.delete(); n32 = 0;
      chk("rst_out_valid32", out_valid32, 0);
    end else begin
      chk("word_count32", wc32, n32[15:0]);
      if (out_valid32 && out_ready32) begin
        if (q32.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out32 actual=%0h required=none", out_data32);
        end else begin
          chk("out_data32", out_data32, q32[0]);
          chk("syndrome32", syndrome({25'd0, out_data32}, 39), 0);
          chk("parity32", ^out_data32, 0);
          chk("extract32", extract32(out_data32), qd32[0]);
          void'(q32.pop_front()); void'(qd32.pop_front());
          n32++;
        end
      end
      if (in_valid32 && in_ready32) begin
        q32.push_back(ref_encode({32'd0, in_data32}, 39) ^ {25'd0, mask32});
        qd32.push_back(in_data32);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid4 = 1'b0; in_valid32 = 1'b0; mask4 = '0; mask32 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push4(input logic [3:0] d, input logic [7:0] m, output bit rdy0);
    int g;
    in_valid4 = 1'b1; in_data4 = d; mask4 = m;
    @(negedge clk);
    rdy0 = in_ready4;
    g = 0;
    while (!in_ready4 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready4) begin
      total++; bad++;
      $display("FAIL push4_timeout actual=stalled required=accept");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r;
    int acc, g;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("model_B", ref_encode(64'hB, 8), 64'hAA);
    chk("model_F", ref_encode(64'hF, 8), 64'hFF);
    chk("model_5", ref_encode(64'h5, 8), 64'h5A);
    chk("model_6", ref_encode(64'h6, 8), 64'h66);

    // Single word, latency and count
    do_reset();
    in_valid4 = 1'b1; in_data4 = 4'hB; mask4 = 8'h00;
    @(negedge clk); chk("t1_in_ready", in_ready4, 1);
    @(posedge clk); #1 in_valid4 = 1'b0;
    @(negedge clk); chk("t1_not_yet", out_valid4, 0);
    @(negedge clk); chk("t1_valid", out_valid4, 1); chk("t1_data", out_data4, 8'hAA);
    @(negedge clk); chk("t1_word_count", wc4, 1);

    // Back-to-back words
    do_reset();
    log4.delete(); logc4.delete();
    push4(4'h0, 8'h00, r); chk("t2_rdy0", r, 1);
    push4(4'hF, 8'h00, r); chk("t2_rdy1", r, 1);
    push4(4'hB, 8'h00, r); chk("t2_rdy2", r, 1);
    in_valid4 = 1'b0;
    repeat (4) @(negedge clk);
    chk("t2_count", log4.size(), 3);
    if (log4.size() == 3) begin
      chk("t2_w0", log4[0], 8'h00);
      chk("t2_w1", log4[1], 8'hFF);
      chk("t2_w2", log4[2], 8'hAA);
      chk("t2_consec01", logc4[1] - logc4[0], 1);
      chk("t2_consec12", logc4[2] - logc4[1], 1);
    end

    // Stall with streaming input
    do_reset();
    log4.delete(); logc4.delete();
    out_ready4 = 1'b0; in_valid4 = 1'b1; in_data4 = 4'h5; mask4 = 8'h00; acc = 0;
    repeat (6) begin
      @(negedge clk);
      if (in_ready4) begin
        acc++;
        @(posedge clk); #1 in_data4 = in_data4 + 4'd1;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    chk("t3_accepts", acc, 2);
    chk("t3_in_ready", in_ready4, 0);
    chk("t3_out_valid", out_valid4, 1);
    chk("t3_held_data", out_data4, 8'h5A);
    chk("t3_none_out", log4.size(), 0);
    @(posedge clk); #1 in_valid4 = 1'b0; out_ready4 = 1'b1;
    repeat (4) @(negedge clk);
    chk("t3_count", log4.size(), 2);
    if (log4.size() == 2) begin
      chk("t3_w0", log4[0], 8'h5A);
      chk("t3_w1", log4[1], 8'h66);
    end

    // Error injection on one word only
    do_reset();
    log4.delete(); logc4.delete();
    push4(4'hB, 8'h08, r);
    push4(4'hB, 8'h00, r);
    in_valid4 = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_count", log4.size(), 2);
    if (log4.size() == 2) begin
      chk("t4_injected", log4[0], 8'hA2);
      chk("t4_clean", log4[1], 8'hAA);
    end
    chk("t4_inj_count", ic4, 1);
    chk("t4_word_count", wc4, 2);

    // Random 32-bit stream with random backpressure
    do_reset();
    acc = 0; g = 0;
    in_valid32 = 1'b1; in_data32 = $urandom; mask32 = '0;
    while (acc < 1000 && g < 10000) begin
      @(negedge clk);
      if (in_valid32 && in_ready32) begin
        acc++;
        @(posedge clk); #1 in_data32 = $urandom;
      end else begin
        @(posedge clk); #1;
      end
      out_ready32 = ($urandom_range(0, 3) != 0);
      in_valid32  = (acc < 1000);
      g++;
    end
    in_valid32 = 1'b0; out_ready32 = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_accepted", acc, 1000);
    chk("t5_emitted", n32, 1000);
    chk("t5_word_count", wc32, 16'd1000);
    chk("t5_inj_count", ic32, 0);

    // Reset with two words in flight
    do_reset();
    out_ready4 = 1'b0;
    push4(4'h3, 8'h00, r);
    push4(4'hC, 8'h01, r);
    in_valid4 = 1'b0;
    @(negedge clk); chk("t6_full", out_valid4, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); chk("t6_rst_out_valid", out_valid4, 0);
    @(posedge clk); #1 rst = 1'b0; out_ready4 = 1'b1;
    log4.delete(); logc4.delete();
    @(negedge clk);
    chk("t6_out_valid", out_valid4, 0);
    chk("t6_word_count", wc4, 0);
    chk("t6_inj_count", ic4, 0);
    repeat (5) @(negedge clk);
    chk("t6_no_stale", log4.size(), 0);

    // Counter wrap over 65536 transfers, every other word injected
    do_reset();
    out_ready4 = 1'b1; in_valid4 = 1'b1; in_data4 = 4'h0; mask4 = 8'h00;
    acc = 0; g = 0;
    while (acc < 65536 && g < 70000) begin
      @(negedge clk);
      if (in_ready4) acc++;
      @(posedge clk); #1;
      in_data4 = acc[3:0];
      mask4    = acc[0] ? 8'h01 : 8'h00;
      if (acc >= 65536) in_valid4 = 1'b0;
      g++;
    end
    in_valid4 = 1'b0;
    repeat (4) @(negedge clk);
    chk("wrap_accepted", acc, 65536);
    chk("wrap_transfers", n4, 65536);
    chk("wrap_word_count", wc4, 16'h0000);
    chk("wrap_inj_count", ic4, 16'h8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
